// File: rtl/register_access_controller.sv
// Initiator-side sequencer for the 16x8 register unit.
// Turns read/write/copy/clear-all commands into load/addr/data pin sequences.
module register_access_controller #(
  parameter int REG_COUNT    = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_dst,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  busy,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_data_out
);

  localparam int CW = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(REG_COUNT - 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CP  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP,
    S_CP_WR,
    S_CLR
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  busy_q, busy_d;
  logic                  rf_load_q, rf_load_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_in_q, rf_data_in_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_idx_d    = clr_idx_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    busy_d       = busy_q;
    rf_load_d    = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_in_d = rf_data_in_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          src_d       = req_addr;
          dst_d       = req_dst;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          unique case (req_op)
            OP_WR: begin
              state_d      = S_WR;
              rf_load_d    = 1'b1;
              rf_addr_d    = req_addr;
              rf_data_in_d = req_data;
            end
            OP_RD, OP_CP: begin
              state_d   = S_RD;
              rf_addr_d = req_addr;
            end
            OP_CLR: begin
              state_d      = S_CLR;
              clr_idx_d    = '0;
              rf_load_d    = 1'b1;
              rf_addr_d    = '0;
              rf_data_in_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_WR, S_CP_WR: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      S_RD: begin
        // addr has been held long enough for data_out to reflect it
        if (cnt_q == CNT_LAST) begin
          if (op_q == OP_CP) begin
            state_d      = S_CP_WR;
            rf_load_d    = 1'b1;
            rf_addr_d    = dst_q;
            rf_data_in_d = rf_data_out;
          end else begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rf_data_out;
            rsp_addr_d  = src_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      S_CLR: begin
        if (clr_idx_q == IDX_LAST) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          rf_load_d = 1'b1;
          rf_addr_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      clr_idx_q    <= '0;
      op_q         <= OP_RD;
      src_q        <= '0;
      dst_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      busy_q       <= 1'b0;
      rf_load_q    <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_in_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_idx_q    <= clr_idx_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      busy_q       <= busy_d;
      rf_load_q    <= rf_load_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_in_q <= rf_data_in_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_addr   = rsp_addr_q;
  assign busy       = busy_q;
  assign rf_load    = rf_load_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data_in = rf_data_in_q;

endmodule
